// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: widths, base opcodes and the fetch front-end state/entry types.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    // opcode[6:2] values; opcode[1:0] is always 2'b11 for 32-bit encodings
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic {
        FETCH,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with first-word fall-through head and a flush.
module riscv_fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction-fetch front end: PC sequencing, credit-limited memory requests, redirect flush.
module riscv_ifetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [ILEN-1:0]  imem_rsp_data,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [ILEN-1:0]  instr_data,
    output logic [XLEN-1:0]  instr_pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             fetch_busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] fetch_pc, rsp_pc;
    logic [CW-1:0]   outstanding, outstanding_next;
    logic [CW-1:0]   discard, discard_next;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full;
    logic            run, credit_ok, req_hs, push, pop;
    fetch_entry_t    head;

    riscv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ('{pc: rsp_pc, instr: imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Buffered plus in-flight words may never exceed the buffer size, so a push always fits.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        req_hs           = imem_req_valid && imem_req_ready;
        pop              = instr_valid && instr_ready && !redirect_valid;
        push             = imem_rsp_valid && (discard == '0) && !redirect_valid;
        outstanding_next = outstanding + CW'(req_hs) - CW'(imem_rsp_valid);
        discard_next     = discard;
        if (redirect_valid) begin
            discard_next = outstanding_next;
        end else if (imem_rsp_valid && (discard != '0)) begin
            discard_next = discard - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = (discard_next != '0) ? FLUSH : FETCH;
        end else if ((state == FLUSH) && (discard == '0)) begin
            state_next = FETCH;
        end
    end

    // run holds requests off until the first clock edge after reset release.
    always_comb begin
        imem_req_valid = run && (state == FETCH) && credit_ok && !redirect_valid;
        fetch_busy     = (outstanding != '0) || (state == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding_next;
            discard     <= discard_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'h3;
                rsp_pc   <= redirect_pc & ~32'h3;
            end else begin
                if (req_hs) fetch_pc <= fetch_pc + 32'd4;
                if (push)   rsp_pc   <= rsp_pc + 32'd4;
            end
            assert (!(push && fifo_full && !pop));
        end
    end

    assign imem_req_addr = fetch_pc;
    assign instr_valid   = !fifo_empty;
    assign instr_data    = head.instr;
    assign instr_pc      = head.pc;

endmodule

// File: tb/tb_riscv_ifetch.sv
// Randomized bench for riscv_ifetch against a transaction-level model of fetch, memory and redirects.
module tb_riscv_ifetch;

    localparam int unsigned   D   = 2;
    localparam logic [31:0]   RPC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_busy;

    always #5 clk = ~clk;

    riscv_ifetch #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_busy     (fetch_busy)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    // pend: requests the memory still owes; bufq: PCs of valid words held for decode.
    mreq_t       pend[$];
    logic [31:0] bufq[$];
    int          epoch, cyc;
    logic [31:0] exp_fetch;
    bit          flush_tail;
    int          rdy_pct, mrdy_pct, lat_max;
    int          n_chk, n_err, n_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        bufq.delete();
        epoch      = 0;
        exp_fetch  = RPC;
        flush_tail = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, imem_req_valid, 0);
        check_eq({tag, "_req_addr"}, imem_req_addr, RPC);
        check_eq({tag, "_instr_valid"}, instr_valid, 0);
        check_eq({tag, "_instr_pc"}, instr_pc, 0);
        check_eq({tag, "_instr_data"}, instr_data, 0);
        check_eq({tag, "_busy"}, fetch_busy, 0);
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    // Entered at posedge+1: drive, check at the falling edge, then advance the model at the rising edge.
    task automatic cycle(input bit rd, input logic [31:0] rpc);
        int    stale;
        bit    rv, req_hs, pop, exp_req;
        mreq_t e;
        rv = (pend.size() != 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? mem_word(pend[0].addr) : 32'h0;
        redirect_valid = rd;
        redirect_pc    = rpc;
        instr_ready    = ($urandom_range(99) < rdy_pct);
        imem_req_ready = ($urandom_range(99) < mrdy_pct);
        #4;
        stale = 0;
        foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
        exp_req = !rd && (stale == 0) && !flush_tail && (pend.size() + bufq.size() < D);
        check_eq("req_valid", imem_req_valid, exp_req);
        check_eq("instr_valid", instr_valid, bufq.size() != 0);
        check_eq("fetch_busy", fetch_busy, (pend.size() != 0) || flush_tail);
        if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_fetch);
        if (instr_valid && bufq.size() != 0) begin
            check_eq("instr_pc", instr_pc, bufq[0]);
            check_eq("instr_data", instr_data, mem_word(bufq[0]));
        end
        req_hs = imem_req_valid && imem_req_ready;
        pop    = instr_valid && instr_ready && !rd;
        @(posedge clk);
        if (rv) begin
            e = pend.pop_front();
            if (e.epoch == epoch && !rd) bufq.push_back(e.addr);
        end
        if (pop && bufq.size() != 0) begin
            void'(bufq.pop_front());
            n_pop++;
        end
        if (req_hs) begin
            pend.push_back('{exp_fetch, epoch, cyc + 1 + int'($urandom_range(lat_max))});
            exp_fetch += 32'd4;
        end
        flush_tail = (stale > 0) && !rd;
        if (rd) begin
            epoch++;
            bufq.delete();
            exp_fetch = rpc & ~32'h3;
        end
        cyc++;
        #1;
    endtask

    initial begin
        int  guard;
        bit  found;
        n_chk = 0; n_err = 0; n_pop = 0; cyc = 0;
        rdy_pct = 100; mrdy_pct = 100; lat_max = 0;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // sequential fetch from a PC near the top of the address space, wrapping to 0
        repeat (16) cycle(1'b0, '0);

        // decode stalled: requests stop once the buffer credit is used up
        rdy_pct = 0;
        repeat (10) cycle(1'b0, '0);
        check_eq("stall_fill", pend.size() + bufq.size(), D);
        rdy_pct = 100;
        repeat (10) cycle(1'b0, '0);

        // redirect with two requests in flight
        lat_max = 5;
        guard = 0;
        while (pend.size() != D && guard < 50) begin
            cycle(1'b0, '0);
            guard++;
        end
        check_eq("redir_setup", pend.size(), D);
        cycle(1'b1, 32'h0000_0103);
        lat_max = 0;
        repeat (20) cycle(1'b0, '0);

        // redirect coinciding with a pop and a response
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (bufq.size() != 0 && pend.size() != 0 && pend[0].due <= cyc) begin
                cycle(1'b1, 32'h0000_0200);
                found = 1'b1;
            end else begin
                cycle(1'b0, '0);
            end
        end
        check_eq("coincide_setup", found, 1);
        repeat (10) cycle(1'b0, '0);

        // asynchronous reset with reads outstanding
        lat_max = 3;
        guard = 0;
        while (pend.size() != D && guard < 50) begin
            cycle(1'b0, '0);
            guard++;
        end
        check_eq("midrst_setup", pend.size(), D);
        #1 rst_n = 1'b0;
        idle_inputs();
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        lat_max = 0;
        repeat (20) cycle(1'b0, '0);

        // randomized traffic with occasional redirects
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                rdy_pct  = int'($urandom_range(100, 30));
                mrdy_pct = int'($urandom_range(100, 30));
                lat_max  = int'($urandom_range(3));
            end
            if ($urandom_range(99) < 4) cycle(1'b1, $urandom);
            else                        cycle(1'b0, '0);
        end
        check_eq("progress", n_pop > 300, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
